// File: rtl/bram_stream_reader.sv
// Streams a burst of words out of a HIGH_PERFORMANCE block RAM.
// Reads are issued against a credit count (buffered + in-flight words), so the
// small first-word-fall-through FIFO on the output can never overflow, and the
// consumer can stall at any time without losing words.
module bram_stream_reader #(
  parameter int DATA_WIDTH   = 18,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_regce,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  // FIFO entry carries the last-word flag alongside the data
  typedef logic [DATA_WIDTH:0] entry_t;

  logic [1:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY-1:0] last_pipe_q, last_pipe_d;
  entry_t                  fifo_q [FIFO_DEPTH];
  entry_t                  fifo_d [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           occ_q, occ_d;
  logic                    done_q, done_d;
  logic                    last_acc_q, last_acc_d;

  logic [CW-1:0]           inflight;
  logic                    issue, wr, rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Count reads still travelling through the RAM pipeline
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(vld_pipe_q[i]);
  end

  // Credit check: buffered + in-flight must stay below the FIFO depth.
  // Outputs are gated by rst so the reset cycle itself already looks idle.
  always_comb begin
    issue     = !rst && (state_q == S_ISSUE) &&
                (({1'b0, occ_q} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH));
    wr        = vld_pipe_q[READ_LATENCY-1];
    m_valid   = !rst && (occ_q != '0);
    rd        = m_valid && m_ready;
    m_data    = fifo_q[rd_ptr_q][DATA_WIDTH-1:0];
    m_last    = m_valid && fifo_q[rd_ptr_q][DATA_WIDTH];
    busy      = !rst && (state_q != S_IDLE);
    done      = !rst && done_q;
    ram_en    = issue;
    ram_addr  = rst ? '0 : addr_q;
    ram_regce = 1'b1;
  end

  // Valid/last shift register tracking each read until its data lands
  always_comb begin
    vld_pipe_d     = '0;
    last_pipe_d    = '0;
    vld_pipe_d[0]  = issue;
    last_pipe_d[0] = issue && (rem_q == (ADDR_WIDTH+1)'(1));
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end
  end

  // First-word-fall-through FIFO; simultaneous write+read keeps occupancy
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr) begin
      fifo_d[wr_ptr_q] = {last_pipe_q[READ_LATENCY-1], ram_dout};
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (rd) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr, rd})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Burst control FSM; FINISH lingers one extra cycle to present the done pulse
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    last_acc_d = last_acc_q || (rd && m_last);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          rem_d      = length;
          last_acc_d = 1'b0;
          state_d    = (length == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - (ADDR_WIDTH+1)'(1);
          if (rem_q == (ADDR_WIDTH+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((inflight == '0) && (occ_q == '0) && last_acc_q) state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d = !done_q;
        if (done_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards everything buffered or in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      done_q      <= 1'b0;
      last_acc_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      done_q      <= done_d;
      last_acc_q  <= last_acc_d;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: a 2-cycle HIGH_PERFORMANCE RAM model feeds
// the DUT; expected words come from a queue built from the burst parameters.
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic        busy, done, ram_en, ram_regce;
  logic [9:0]  ram_addr;
  logic [17:0] ram_dout;
  logic [17:0] m_data;
  logic        m_valid, m_ready, m_last;

  bram_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_regce(ram_regce), .ram_dout(ram_dout), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // RAM with output register: data for a read issued in cycle N shows in N+2
  logic [17:0] mem [1024];
  logic [17:0] ram_lat;
  always @(posedge clk) begin
    if (ram_en) ram_lat <= mem[ram_addr];
    if (ram_regce) ram_dout <= ram_lat;
  end

  int n_vec = 0, n_bad = 0;
  int cyc_n = 0;
  logic [18:0] exp_q[$];
  int bbase, blen, iss_n, acc_n, done_cnt, busy_cnt, done_cyc, prev_acc_cyc;
  bit tput, was_hold;
  logic [18:0] hold_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, update the model, return just after posedge
  task automatic cyc();
    logic [18:0] w;
    @(negedge clk);
    cyc_n++;
    chk("regce", {31'd0, ram_regce}, 1);
    if (ram_en) begin
      chk("ram_addr", {22'd0, ram_addr}, (bbase + iss_n) % 1024);
      iss_n++;
      chk("over_issue", {31'd0, iss_n <= blen}, 1);
      chk("credit", {31'd0, (iss_n - acc_n) <= 4}, 1);
    end
    if (was_hold && !rst) begin
      chk("hold_valid", {31'd0, m_valid}, 1);
      chk("hold_data", {13'd0, m_last, m_data}, {13'd0, hold_word});
    end
    was_hold  = m_valid && !m_ready;
    hold_word = {m_last, m_data};
    if (m_valid && m_ready) begin
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk("word", {13'd0, m_last, m_data}, {13'd0, w});
      acc_n++;
      if (tput && acc_n > 1) chk("gap", cyc_n - prev_acc_cyc, 1);
      prev_acc_cyc = cyc_n;
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc_n;
      chk("busy_at_done", {31'd0, busy}, 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int mode, input int c);
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = (c >= 4 && c < 14) ? 1'b0 : 1'($urandom_range(0, 1));
    endcase
  endtask

  // Full burst; restart_at >= 0 pulses a second (ignored) start mid-burst
  task automatic run_burst(input int base, input int len, input int mode, input int restart_at);
    int post, start_cyc;
    exp_q.delete();
    for (int k = 0; k < len; k++)
      exp_q.push_back({(k == len - 1) ? 1'b1 : 1'b0, mem[(base + k) % 1024]});
    bbase = base; blen = len; iss_n = 0; acc_n = 0;
    done_cnt = 0; busy_cnt = 0; done_cyc = -1; was_hold = 0;
    tput = (mode == 0);
    start = 1'b1; base_addr = 10'(base); length = 11'(len);
    set_ready(mode, 0);
    start_cyc = cyc_n + 1;
    cyc();
    start = 1'b0;
    post = -1;
    for (int c = 1; c < 400 && post != 0; c++) begin
      set_ready(mode, c);
      if (c == restart_at) begin
        start = 1'b1; base_addr = 10'd77; length = 11'd5;
      end
      cyc();
      start = 1'b0;
      if (done_cnt > 0 && post < 0) post = 4;
      else if (post > 0) post--;
    end
    chk("done_count", done_cnt, 1);
    chk("words_left", exp_q.size(), 0);
    chk("issued", iss_n, len);
    chk("accepted", acc_n, len);
    chk("idle_after", {31'd0, busy}, 0);
    if (len == 0) begin
      chk("len0_busy_cycles", busy_cnt, 2);
      chk("len0_done_cycle", done_cyc - start_cyc, 2);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_ram_en"}, {31'd0, ram_en}, 0);
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 0);
    chk({tag, "_m_last"}, {31'd0, m_last}, 0);
    chk({tag, "_ram_addr"}, {22'd0, ram_addr}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    bbase = 0; blen = 0; iss_n = 0; acc_n = 0; was_hold = 0; tput = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 18'(i);
    cyc(); cyc();
    chk("rst_regce", {31'd0, ram_regce}, 1);
    rst = 1'b0;
    chk_quiet("reset");

    // In-order burst at full rate
    run_burst(5, 8, 0, -1);
    // Address wrap at the top of the RAM
    run_burst(1022, 4, 0, -1);
    // Back-pressure including a 10-cycle stall
    run_burst(100, 16, 2, -1);
    // Empty burst
    run_burst(300, 0, 0, -1);
    // Second start while busy is ignored
    run_burst(40, 6, 1, 3);

    // Reset in the middle of a long burst
    exp_q.delete(); bbase = 200; blen = 20; iss_n = 0; acc_n = 0; was_hold = 0; tput = 0;
    start = 1'b1; base_addr = 10'd200; length = 11'd20; m_ready = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_quiet("midrst");
    exp_q.delete(); blen = 0; done_cnt = 0; was_hold = 0;
    for (int c = 0; c < 6; c++) cyc();
    chk("midrst_no_done", done_cnt, 0);
    run_burst(500, 2, 0, -1);

    // Randomized bursts over random RAM contents
    for (int i = 0; i < 1024; i++) mem[i] = 18'($urandom);
    for (int t = 0; t < 6; t++)
      run_burst((t == 2) ? 1020 : int'($urandom_range(0, 1023)),
                int'($urandom_range(1, 24)), int'($urandom_range(0, 2)), -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
